// File: rtl/stage_cp_broadcast_if.sv
// stage_cp_broadcast_if: EX result handshake and CDB broadcast bundle
interface stage_cp_broadcast_if #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5,
    parameter int XLEN  = 32
);
    logic                     ex_valid;
    logic [XLEN-1:0]          ex_value;
    logic [TAG_W-1:0]         ex_rob_tag;
    logic                     ex_take_branch;
    logic                     cdb_stall;
    logic                     flush;
    logic                     cdb_busy;
    logic                     cdb_valid;
    logic [XLEN-1:0]          cdb_value;
    logic [TAG_W-1:0]         cdb_rob_tag;
    logic                     cdb_take_branch;
    logic                     overflow_err;
    logic [$clog2(DEPTH):0]   occupancy;

    modport master (
        output ex_valid, ex_value, ex_rob_tag, ex_take_branch, cdb_stall, flush,
        input  cdb_busy, cdb_valid, cdb_value, cdb_rob_tag, cdb_take_branch, overflow_err, occupancy
    );

    modport slave (
        input  ex_valid, ex_value, ex_rob_tag, ex_take_branch, cdb_stall, flush,
        output cdb_busy, cdb_valid, cdb_value, cdb_rob_tag, cdb_take_branch, overflow_err, occupancy
    );
endinterface

// File: rtl/stage_cp_broadcast.sv
// stage_cp_broadcast: in-order result FIFO feeding a registered CDB broadcast with EX back-pressure
module stage_cp_broadcast #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5,
    parameter int XLEN  = 32
) (
    input logic              clk,
    input logic              rst_n,
    stage_cp_broadcast_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [XLEN-1:0]  value;
        logic [TAG_W-1:0] tag;
        logic             take_branch;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    entry_t          cdb_q, cdb_d;
    logic            cdb_valid_q, cdb_valid_d;
    logic            ovf_q, ovf_d;
    logic            pop, push;

    // A full FIFO still accepts when the head leaves on the same edge; flush overrides everything
    always_comb begin
        pop         = !bus.flush && !bus.cdb_stall && count_q != '0;
        push        = bus.ex_valid && !bus.flush && (count_q != CW'(DEPTH) || pop);
        head_d      = bus.flush ? '0 : head_q + AW'(pop);
        tail_d      = bus.flush ? '0 : tail_q + AW'(push);
        count_d     = bus.flush ? '0 : count_q + CW'(push) - CW'(pop);
        cdb_d       = pop ? mem_q[head_q] : cdb_q;
        cdb_valid_d = bus.flush ? 1'b0 : bus.cdb_stall ? cdb_valid_q : pop;
        ovf_d       = ovf_q | (bus.ex_valid && !bus.flush && !push);
    end

    // Result storage needs no reset; only pointers and count define validity
    always_ff @(posedge clk) begin
        if (push) mem_q[tail_q] <= {bus.ex_value, bus.ex_rob_tag, bus.ex_take_branch};
    end

    // Pointers, count, CDB output register and sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            cdb_q       <= '0;
            cdb_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            cdb_q       <= cdb_d;
            cdb_valid_q <= cdb_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    // Busy one entry early so a result EX issues in the same cycle still fits
    assign bus.cdb_busy = (count_q >= CW'(DEPTH - 1)) |
                          (count_q == CW'(DEPTH - 2) && bus.ex_valid && bus.cdb_stall);
    assign bus.cdb_valid       = cdb_valid_q;
    assign bus.cdb_value       = cdb_q.value;
    assign bus.cdb_rob_tag     = cdb_q.tag;
    assign bus.cdb_take_branch = cdb_q.take_branch;
    assign bus.overflow_err    = ovf_q;
    assign bus.occupancy       = count_q;
endmodule

// File: tb/tb_stage_cp_broadcast.sv
// tb_stage_cp_broadcast: directed self-checking bench for the CDB broadcast stage
module tb_stage_cp_broadcast;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    stage_cp_broadcast_if #(.DEPTH(4), .TAG_W(5), .XLEN(32)) b ();

    stage_cp_broadcast #(.DEPTH(4), .TAG_W(5), .XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic ev, input logic [4:0] t, input logic [31:0] v);
        b.ex_valid       = ev;
        b.ex_rob_tag     = t;
        b.ex_value       = v;
        b.ex_take_branch = t[0];
    endtask

    task automatic do_reset();
        drv(1'b0, 5'd0, 32'd0);
        b.cdb_stall = 1'b0;
        b.flush     = 1'b0;
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int q[$];
        logic mv, ev4, st4, pop4;
        int mtag, np;
        drv(1'b0, 5'd0, 32'd0);
        b.cdb_stall = 1'b0;
        b.flush     = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid", b.cdb_valid, 0);
        chk("rst_occ", b.occupancy, 0);
        chk("rst_busy", b.cdb_busy, 0);
        chk("rst_ovf", b.overflow_err, 0);
        tick();
        tick();
        rst_n = 1'b1;
        // Mid-cycle asynchronous reset while a result is on the CDB
        drv(1'b1, 5'd7, 32'hAA);
        tick();
        chk("pre_occ", b.occupancy, 1);
        drv(1'b0, 5'd0, 32'd0);
        tick();
        chk("pre_valid", b.cdb_valid, 1);
        chk("pre_value", b.cdb_value, 32'hAA);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", b.cdb_valid, 0);
        chk("arst_value", b.cdb_value, 0);
        chk("arst_tag", b.cdb_rob_tag, 0);
        chk("arst_tb", b.cdb_take_branch, 0);
        chk("arst_occ", b.occupancy, 0);
        #1 rst_n = 1'b1;
        tick();
        // Test 1: single result latency
        drv(1'b1, 5'd1, 32'd15);
        tick();
        chk("t1_valid_n", b.cdb_valid, 0);
        chk("t1_occ_n", b.occupancy, 1);
        drv(1'b0, 5'd0, 32'd0);
        tick();
        chk("t1_valid", b.cdb_valid, 1);
        chk("t1_value", b.cdb_value, 15);
        chk("t1_tag", b.cdb_rob_tag, 1);
        chk("t1_tb", b.cdb_take_branch, 1);
        tick();
        chk("t1_valid_off", b.cdb_valid, 0);
        // Test 2: back-to-back
        drv(1'b1, 5'd1, 32'd15);
        tick();
        chk("t2_occ0", b.occupancy, 1);
        drv(1'b1, 5'd2, 32'd5);
        tick();
        chk("t2_occ1", b.occupancy, 1);
        chk("t2_tag1", b.cdb_rob_tag, 1);
        chk("t2_val1", b.cdb_value, 15);
        drv(1'b1, 5'd3, 32'h0F00);
        tick();
        chk("t2_occ2", b.occupancy, 1);
        chk("t2_tag2", b.cdb_rob_tag, 2);
        chk("t2_val2", b.cdb_value, 5);
        drv(1'b0, 5'd0, 32'd0);
        tick();
        chk("t2_occ3", b.occupancy, 0);
        chk("t2_valid3", b.cdb_valid, 1);
        chk("t2_tag3", b.cdb_rob_tag, 3);
        chk("t2_val3", b.cdb_value, 32'h0F00);
        tick();
        chk("t2_valid_off", b.cdb_valid, 0);
        // Test 3: stall, busy, overflow, drain
        drv(1'b1, 5'd10, 32'd100);
        tick();
        drv(1'b1, 5'd11, 32'd101);
        tick();
        chk("t3_head_tag", b.cdb_rob_tag, 10);
        b.cdb_stall = 1'b1;
        drv(1'b1, 5'd12, 32'd102);
        #1;
        chk("t3_busy_c1", b.cdb_busy, 0);
        tick();
        chk("t3_occ2", b.occupancy, 2);
        drv(1'b0, 5'd0, 32'd0);
        #1;
        chk("t3_busy_c2_idle", b.cdb_busy, 0);
        drv(1'b1, 5'd13, 32'd103);
        #1;
        chk("t3_busy_c2_ev", b.cdb_busy, 1);
        tick();
        chk("t3_occ3", b.occupancy, 3);
        chk("t3_busy_c3", b.cdb_busy, 1);
        drv(1'b1, 5'd14, 32'd104);
        tick();
        chk("t3_occ4", b.occupancy, 4);
        chk("t3_ovf0", b.overflow_err, 0);
        chk("t3_hold_valid", b.cdb_valid, 1);
        chk("t3_hold_tag", b.cdb_rob_tag, 10);
        drv(1'b1, 5'd15, 32'd105);
        tick();
        chk("t3_ovf1", b.overflow_err, 1);
        chk("t3_occ_ovf", b.occupancy, 4);
        drv(1'b0, 5'd0, 32'd0);
        b.cdb_stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t3_drain_valid", b.cdb_valid, 1);
            chk("t3_drain_tag", b.cdb_rob_tag, 11 + k);
            chk("t3_drain_val", b.cdb_value, 101 + k);
            chk("t3_drain_occ", b.occupancy, 3 - k);
        end
        tick();
        chk("t3_end_valid", b.cdb_valid, 0);
        chk("t3_ovf_sticky", b.overflow_err, 1);
        do_reset();
        chk("t3_ovf_cleared", b.overflow_err, 0);
        // Test 4: wrap-around with toggling stall
        mv = 1'b0;
        mtag = 0;
        np = 0;
        for (int i = 0; i < 26; i++) begin
            st4 = i[0];
            ev4 = (i % 2 == 0) && np < 10;
            drv(ev4, np[4:0], 32'(np * 3 + 1));
            b.cdb_stall = st4;
            pop4 = !st4 && q.size() > 0;
            if (pop4) begin
                mtag = q.pop_front();
                mv = 1'b1;
            end else if (!st4) begin
                mv = 1'b0;
            end
            if (ev4) begin
                q.push_back(np);
                np++;
            end
            tick();
            chk("t4_valid", b.cdb_valid, mv);
            if (mv) begin
                chk("t4_tag", b.cdb_rob_tag, mtag);
                chk("t4_val", b.cdb_value, mtag * 3 + 1);
            end
            chk("t4_occ", b.occupancy, q.size());
        end
        chk("t4_ovf", b.overflow_err, 0);
        // Test 5: flush with count 3, CDB valid, and a simultaneous push
        drv(1'b0, 5'd0, 32'd0);
        b.cdb_stall = 1'b0;
        drv(1'b1, 5'd20, 32'd200);
        tick();
        drv(1'b1, 5'd21, 32'd201);
        tick();
        b.cdb_stall = 1'b1;
        drv(1'b1, 5'd22, 32'd202);
        tick();
        drv(1'b1, 5'd23, 32'd203);
        tick();
        chk("t5_pre_occ", b.occupancy, 3);
        chk("t5_pre_valid", b.cdb_valid, 1);
        b.flush = 1'b1;
        drv(1'b1, 5'd9, 32'd6);
        tick();
        chk("t5_valid", b.cdb_valid, 0);
        chk("t5_occ", b.occupancy, 0);
        b.flush = 1'b0;
        b.cdb_stall = 1'b0;
        drv(1'b0, 5'd0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t5_no_tag9", b.cdb_valid, 0);
        end
        chk("t5_ovf", b.overflow_err, 0);
        // Test 6: push into a full FIFO while popping
        b.cdb_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drv(1'b1, 5'(k), 32'(16 + k));
            tick();
        end
        chk("t6_full", b.occupancy, 4);
        b.cdb_stall = 1'b0;
        drv(1'b1, 5'd4, 32'hE0000000);
        tick();
        chk("t6_occ", b.occupancy, 4);
        chk("t6_ovf", b.overflow_err, 0);
        chk("t6_tag0", b.cdb_rob_tag, 0);
        drv(1'b0, 5'd0, 32'd0);
        for (int k = 1; k < 4; k++) begin
            tick();
            chk("t6_tag", b.cdb_rob_tag, k);
            chk("t6_val", b.cdb_value, 16 + k);
        end
        tick();
        chk("t6_last_valid", b.cdb_valid, 1);
        chk("t6_last_tag", b.cdb_rob_tag, 4);
        chk("t6_last_val", b.cdb_value, 32'hE0000000);
        chk("t6_last_occ", b.occupancy, 0);
        tick();
        chk("t6_end_valid", b.cdb_valid, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/stage_cp_broadcast.md
Name: stage_cp_broadcast

Overview:
- Completion-side receiver for the execute stage's result packets.
- Accepts one result per cycle from EX (value, ROB tag, branch-taken flag) into a small in-order FIFO.
- Broadcasts one result per cycle on the CDB to ROB/RS and drives the busy back-pressure signal that EX samples as cdb_packet_busy.
- Absorbs the multi-cycle multiplier completing in the same window as single-cycle ALUs while the CDB is stalled.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- TAG_W, 5, ROB tag width.
- XLEN, 32, result value width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  EX result valid this cycle.
- ex_value  in  XLEN  EX result value.
- ex_rob_tag  in  TAG_W  ROB tag of the EX result.
- ex_take_branch  in  1  conditional-branch-taken flag from EX.
- cdb_stall  in  1  CDB consumer cannot accept a broadcast this cycle.
- flush  in  1  squash; discards all buffered and broadcasting results.
- cdb_busy  out  1  back-pressure to EX (EX's cdb_packet_busy).
- cdb_valid  out  1  CDB broadcast valid.
- cdb_value  out  XLEN  broadcast value.
- cdb_rob_tag  out  TAG_W  broadcast ROB tag.
- cdb_take_branch  out  1  broadcast branch-taken flag.
- overflow_err  out  1  sticky error: result arrived while FIFO full.
- occupancy  out  clog2(DEPTH)+1  current FIFO entry count.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - head=tail=0, count=0.
  - cdb_valid=0, cdb_value=0, cdb_rob_tag=0, cdb_take_branch=0.
  - cdb_busy=0, overflow_err=0, occupancy=0.
  - Reset deasserted mid-stream: all in-flight results are lost, with no partial broadcast.
- Storage:
  - Circular buffer; head/tail pointers wrap modulo DEPTH.
  - count tracks fullness and distinguishes full from empty when head==tail.
- Enqueue:
  - At posedge, if ex_valid and (count<DEPTH or a pop occurs the same edge), write {value, tag, take_branch} at tail; tail++.
- Dequeue / CDB output register:
  - At posedge, if cdb_stall=0 and count>0, load head entry into the cdb_* registers, set cdb_valid=1, head++.
  - If cdb_stall=0 and count==0, cdb_valid<=0.
  - If cdb_stall=1, all cdb_* registers hold their values (valid stays asserted). Each result is broadcast exactly once after stall release.
- Latency: ex_valid at edge N with empty FIFO and no stall gives the result in the FIFO after edge N and cdb_valid=1 after edge N+1. Minimum latency is 2 cycles.
- Simultaneous push and pop: count unchanged. A push to a full FIFO is accepted if a pop happens at the same edge.
- Overflow: ex_valid, count==DEPTH and no pop means the result is dropped, overflow_err<=1 (sticky until reset), and the FIFO is unchanged.
- cdb_busy:
  - Combinational: cdb_busy = (count >= DEPTH-1) | (count==DEPTH-2 & ex_valid & cdb_stall).
  - This guarantees that one result issued the cycle busy is seen still fits.
- flush:
  - Synchronous, highest priority over push and pop.
  - Next edge: count=0, head=tail=0, cdb_valid=0; ex_valid that cycle is discarded; overflow_err unaffected.
- Ordering: strict FIFO; broadcast order equals EX arrival order.
- occupancy mirrors count.

Test Plan:
1. Reset with rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately. Release, then ex_valid=1, value=15, tag=1 -> cdb_valid=1, value=15, tag=1 two edges later, and cdb_valid=0 the following cycle.
2. Back-to-back: values 15, 5, 0x0F00 with tags 1, 2, 3 on consecutive cycles, no stall -> three consecutive CDB broadcasts in order; occupancy never exceeds 1.
3. cdb_stall=1 while pushing 4 results (DEPTH=4):
   - cdb_busy asserts at count 3.
   - Fifth push -> overflow_err=1 and the dropped result never appears.
   - Release stall -> the 4 results drain in order, with the held head broadcast exactly once.
4. Wrap-around: push and pop 10 results with cdb_stall toggling every other cycle -> all 10 broadcast in order (tags 0-9); pointers wrap cleanly.
5. flush with count=3, cdb_valid=1 and a simultaneous ex_valid (tag 9, value 6) -> next cycle cdb_valid=0 and occupancy=0; tag 9 is never broadcast.
6. Full FIFO, cdb_stall=0, ex_valid=1 (value 0xE0000000, tag 4) -> accepted with no overflow; occupancy stays 4; tag 4 is broadcast last.
